// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage hazard controller: FSM states, XZR and the control bundle.
// Optional counters in hazard_unit are enabled with HAZARD_PERF_CNT_EN.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hazard_state_e;

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic exmem_write;
    logic idex_bubble;
    logic memwb_bubble;
    logic ifid_flush;
    logic idex_flush;
  } hazard_ctrl_t;

  localparam hazard_ctrl_t CTRL_NORMAL = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam hazard_ctrl_t CTRL_LU     = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam hazard_ctrl_t CTRL_BR     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam hazard_ctrl_t CTRL_FZ     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam hazard_ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/hazard_wait_timer.sv
// Memory-wait watchdog: counts consecutive not-ready MEM_WAIT cycles and holds a sticky timeout flag.
module hazard_wait_timer
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_count,
  input  logic i_set_err,
  output logic o_at_limit,
  output logic o_mem_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_timer;
  logic          r_mem_timeout;

  assign o_at_limit    = (r_timer == TW'(TIMEOUT));
  assign o_mem_timeout = r_mem_timeout;

  // The timer parks at TIMEOUT instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_timer       <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      if (i_load) begin
        r_timer <= TW'(1);
      end else if (i_count && !o_at_limit) begin
        r_timer <= r_timer + 1'b1;
      end
      if (i_set_err) begin
        r_mem_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// ID-stage hazard controller: load-use stalls, branch flushes and memory-wait freezes with watchdog.
// Define HAZARD_PERF_CNT_EN to add the saturating stallCnt/flushCnt/waitCnt counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       RnID,
  input  logic [4:0]       RmID,
  input  logic             useRnID,
  input  logic             useRmID,
  input  logic [4:0]       RdIDEX,
  input  logic             MemReadIDEX,
  input  logic             BrTakenEX,
  input  logic             MemAccessMEM,
  input  logic             memReady,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXWrite,
  output logic             EXMEMWrite,
  output logic             IDEXBubble,
  output logic             MEMWBBubble,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             memTimeout,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt,
  output logic [CNT_W-1:0] waitCnt,
`endif
  output hazard_state_e    o_dbg_state
);

  hazard_state_e r_state, w_state_nxt;
  hazard_ctrl_t  w_ctrl;
  logic          w_lu, w_fz, w_mem_stall, w_at_limit;
  logic          w_load, w_count, w_set_err;
  logic          w_lu_win, w_br_win;

  assign w_mem_stall = MemAccessMEM && !memReady;
  assign w_lu = MemReadIDEX && (RdIDEX != XZR) &&
                ((useRnID && (RdIDEX == RnID)) || (useRmID && (RdIDEX == RmID)));
  assign w_fz     = w_mem_stall || (r_state == ERROR);
  assign w_br_win = !w_fz && BrTakenEX;
  assign w_lu_win = !w_fz && !BrTakenEX && w_lu;

  assign w_load    = (r_state == RUN) && w_mem_stall;
  assign w_count   = (r_state == MEM_WAIT) && !memReady;
  assign w_set_err = (r_state == MEM_WAIT) && !memReady && w_at_limit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:      if (w_mem_stall) w_state_nxt = MEM_WAIT;
      MEM_WAIT: begin
        if (memReady)        w_state_nxt = RUN;
        else if (w_at_limit) w_state_nxt = ERROR;
      end
      ERROR:    w_state_nxt = ERROR;
      default:  w_state_nxt = RUN;
    endcase
  end

  // Reset forces a fully squashed pipeline regardless of current state.
  always_comb begin
    w_ctrl = CTRL_NORMAL;
    if (!reset)         w_ctrl = CTRL_RESET;
    else if (w_fz)      w_ctrl = CTRL_FZ;
    else if (BrTakenEX) w_ctrl = CTRL_BR;
    else if (w_lu)      w_ctrl = CTRL_LU;
  end

  assign PCWrite     = w_ctrl.pc_write;
  assign IFIDWrite   = w_ctrl.ifid_write;
  assign IDEXWrite   = w_ctrl.idex_write;
  assign EXMEMWrite  = w_ctrl.exmem_write;
  assign IDEXBubble  = w_ctrl.idex_bubble;
  assign MEMWBBubble = w_ctrl.memwb_bubble;
  assign IFIDFlush   = w_ctrl.ifid_flush;
  assign IDEXFlush   = w_ctrl.idex_flush;
  assign o_dbg_state = r_state;

  hazard_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .i_clk        (clk),
    .i_rst_n      (reset),
    .i_load       (w_load),
    .i_count      (w_count),
    .i_set_err    (w_set_err),
    .o_at_limit   (w_at_limit),
    .o_mem_timeout(memTimeout)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt, r_wait_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      if (w_lu_win && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_br_win && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
      if (w_fz && (r_wait_cnt != '1))      r_wait_cnt  <= r_wait_cnt + 1'b1;
    end
  end

  assign stallCnt = r_stall_cnt;
  assign flushCnt = r_flush_cnt;
  assign waitCnt  = r_wait_cnt;
`else
  logic w_unused_win;
  assign w_unused_win = w_lu_win ^ w_br_win;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: driver pushes expected controls, negedge monitor pops and compares.
module tb_hazard_unit;
  import hazard_pkg::*;

  localparam int W = 11;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] RnID = '0, RmID = '0, RdIDEX = '0;
  logic useRnID = 1'b0, useRmID = 1'b0, MemReadIDEX = 1'b0;
  logic BrTakenEX = 1'b0, MemAccessMEM = 1'b0, memReady = 1'b0;
  logic PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite;
  logic IDEXBubble, MEMWBBubble, IFIDFlush, IDEXFlush, memTimeout;
  hazard_state_e o_dbg_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCnt, flushCnt, waitCnt;
`endif

  logic [W-1:0] exp_q[$];
  string        nm_q[$];
  int           n_vec  = 0;
  int           n_miss = 0;

  // Expected control words: {PCW, IFIDW, IDEXW, EXMEMW, IDEXB, MEMWBB, IFIDF, IDEXF}
  localparam logic [7:0] E_NORM = 8'b1111_0000;
  localparam logic [7:0] E_LU   = 8'b0011_1000;
  localparam logic [7:0] E_BR   = 8'b1111_0011;
  localparam logic [7:0] E_FZ   = 8'b0000_0100;
  localparam logic [7:0] E_RST  = 8'b0000_1111;

  hazard_unit #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .RnID(RnID), .RmID(RmID), .useRnID(useRnID), .useRmID(useRmID),
    .RdIDEX(RdIDEX), .MemReadIDEX(MemReadIDEX), .BrTakenEX(BrTakenEX),
    .MemAccessMEM(MemAccessMEM), .memReady(memReady),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite), .EXMEMWrite(EXMEMWrite),
    .IDEXBubble(IDEXBubble), .MEMWBBubble(MEMWBBubble), .IFIDFlush(IFIDFlush),
    .IDEXFlush(IDEXFlush), .memTimeout(memTimeout),
`ifdef HAZARD_PERF_CNT_EN
    .stallCnt(stallCnt), .flushCnt(flushCnt), .waitCnt(waitCnt),
`endif
    .o_dbg_state(o_dbg_state)
  );

  // Clock / global time limit
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: run exceeded time limit");
    $fatal(1, "timeout");
  end

  // Driver: one vector per cycle, driven #1 after the rising edge
  task automatic drive(input logic rst, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rn, input logic urn, input logic [4:0] rm,
                       input logic urm, input logic br, input logic ma, input logic rdy,
                       input logic [7:0] ec, input logic eto, input hazard_state_e est,
                       input string nm);
    @(posedge clk);
    #1;
    reset = rst; MemReadIDEX = mr; RdIDEX = rd; RnID = rn; useRnID = urn;
    RmID = rm; useRmID = urm; BrTakenEX = br; MemAccessMEM = ma; memReady = rdy;
    exp_q.push_back({ec, eto, est});
    nm_q.push_back(nm);
  endtask

  task automatic idle(input logic [7:0] ec, input logic eto, input hazard_state_e est,
                      input string nm);
    drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ec, eto, est, nm);
  endtask

  task automatic mem(input logic rdy, input logic br, input logic [7:0] ec, input logic eto,
                     input hazard_state_e est, input string nm);
    drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, br, 1'b1, rdy, ec, eto, est, nm);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] exp_w, act_w;
      string nm;
      exp_w = exp_q.pop_front();
      nm    = nm_q.pop_front();
      act_w = {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IDEXBubble, MEMWBBubble,
               IFIDFlush, IDEXFlush, memTimeout, o_dbg_state};
      n_vec++;
      if (act_w !== exp_w) begin
        n_miss++;
        $display("FAIL %s: got ctrl=%b to=%b st=%0d, want ctrl=%b to=%b st=%0d", nm,
                 act_w[10:3], act_w[2], act_w[1:0], exp_w[10:3], exp_w[2], exp_w[1:0]);
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  task automatic check_cnt(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask
`endif

  initial begin
    repeat (2) @(posedge clk);
    drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RST, 1'b0, RUN, "reset_hold");
    idle(E_NORM, 1'b0, RUN, "first_normal");
    drive(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_LU, 1'b0, RUN, "lu_rn");
    drive(1'b1, 1'b0, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NORM, 1'b0, RUN, "lu_release");
    drive(1'b1, 1'b1, 5'd31, 5'd31, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NORM, 1'b0, RUN, "xzr_dest");
    drive(1'b1, 1'b1, 5'd7, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, E_NORM, 1'b0, RUN, "rm_unused");
    drive(1'b1, 1'b1, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, E_LU, 1'b0, RUN, "lu_rm");
    drive(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_BR, 1'b0, RUN, "br_over_lu");
    mem(1'b0, 1'b0, E_FZ, 1'b0, RUN, "wait1");
    mem(1'b0, 1'b0, E_FZ, 1'b0, MEM_WAIT, "wait2");
    mem(1'b0, 1'b1, E_FZ, 1'b0, MEM_WAIT, "wait3_br_held");
    mem(1'b1, 1'b1, E_BR, 1'b0, MEM_WAIT, "release_br");
    mem(1'b1, 1'b0, E_NORM, 1'b0, RUN, "ready_same_cycle");
    idle(E_NORM, 1'b0, RUN, "idle_after_wait");
`ifdef HAZARD_PERF_CNT_EN
    @(negedge clk);
    check_cnt("stallCnt", stallCnt, 32'd2);
    check_cnt("flushCnt", flushCnt, 32'd2);
    check_cnt("waitCnt", waitCnt, 32'd3);
`endif
    // Ready arrives exactly when the timer sits at TIMEOUT: no error
    mem(1'b0, 1'b0, E_FZ, 1'b0, RUN, "edge_w1");
    mem(1'b0, 1'b0, E_FZ, 1'b0, MEM_WAIT, "edge_w2");
    mem(1'b0, 1'b0, E_FZ, 1'b0, MEM_WAIT, "edge_w3");
    mem(1'b0, 1'b0, E_FZ, 1'b0, MEM_WAIT, "edge_w4");
    mem(1'b1, 1'b0, E_NORM, 1'b0, MEM_WAIT, "edge_ready");
    idle(E_NORM, 1'b0, RUN, "edge_run");
    // Watchdog expiry
    mem(1'b0, 1'b0, E_FZ, 1'b0, RUN, "wd_w0");
    mem(1'b0, 1'b0, E_FZ, 1'b0, MEM_WAIT, "wd_t1");
    mem(1'b0, 1'b0, E_FZ, 1'b0, MEM_WAIT, "wd_t2");
    mem(1'b0, 1'b0, E_FZ, 1'b0, MEM_WAIT, "wd_t3");
    mem(1'b0, 1'b0, E_FZ, 1'b0, MEM_WAIT, "wd_t4");
    mem(1'b0, 1'b0, E_FZ, 1'b1, ERROR, "wd_error");
    mem(1'b1, 1'b0, E_FZ, 1'b1, ERROR, "wd_sticky_ready");
    idle(E_FZ, 1'b1, ERROR, "wd_sticky_idle");
    drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RST, 1'b1, ERROR, "wd_reset");
    idle(E_NORM, 1'b0, RUN, "wd_recovered");
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
